// File: rtl/multi_adder_seq.sv
// multi_adder_seq: collects up to NUM_OPS operands from a valid/ready stream,
// sums them with a combinational multi_adder, and presents the registered
// result on a valid/ready output port. Unfilled slots contribute zero.

// Combinational adder over a flat bank of NUM_OPS unsigned operands.
module multi_adder #(
  parameter int N       = 8,
  parameter int NUM_OPS = 8,
  parameter int SW      = N + $clog2(NUM_OPS)
) (
  input  logic [NUM_OPS*N-1:0] ops_i,
  output logic [SW-1:0]        sum_o
);

  // Straight accumulation; the sum width already covers NUM_OPS*(2^N-1).
  always_comb begin
    logic [SW-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      acc = acc + SW'(ops_i[i*N +: N]);
    end
    sum_o = acc;
  end

endmodule

module multi_adder_seq #(
  parameter int N       = 8,
  parameter int NUM_OPS = 8,
  localparam int SW     = N + $clog2(NUM_OPS),
  localparam int CW     = $clog2(NUM_OPS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_sum,
  output logic [CW-1:0] out_count
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ADD     = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  logic [N-1:0]        slots_q [NUM_OPS];
  logic [SW-1:0]       out_sum_q;
  logic [CW-1:0]       out_count_q;
  logic [NUM_OPS*N-1:0] ops_flat;
  logic [SW-1:0]       sum_w;
  logic                close_group;

  // Present the slot bank to the adder as one flat vector.
  generate
    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_flat
      assign ops_flat[gi*N +: N] = slots_q[gi];
    end
  endgenerate

  multi_adder #(
    .N       (N),
    .NUM_OPS (NUM_OPS),
    .SW      (SW)
  ) u_adder (
    .ops_i (ops_flat),
    .sum_o (sum_w)
  );

  // Next count and group-close decode for an accepted beat.
  always_comb begin
    cnt_d       = cnt_q + CW'(1);
    close_group = in_last || (cnt_q == CW'(NUM_OPS - 1));
  end

  // Handshake flags are pure state decodes; in_ready is gated off during reset.
  assign in_ready  = (state_q == COLLECT) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;

  // Group sequencer: collect operands, register the sum, hold until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      for (int i = 0; i < NUM_OPS; i++) begin
        slots_q[i] <= '0;
      end
    end else begin
      case (state_q)
        COLLECT: begin
          // in_ready is 1 here whenever rst is low, so in_valid alone accepts.
          if (in_valid) begin
            for (int i = 0; i < NUM_OPS; i++) begin
              if (cnt_q == CW'(i)) begin
                slots_q[i] <= in_data;
              end
            end
            cnt_q <= cnt_d;
            if (close_group) begin
              state_q <= ADD;
            end
          end
        end
        ADD: begin
          out_sum_q   <= sum_w;
          out_count_q <= cnt_q;
          state_q     <= DONE;
        end
        DONE: begin
          // Clearing the slots here is what makes short groups sum correctly.
          if (out_ready) begin
            cnt_q <= '0;
            for (int i = 0; i < NUM_OPS; i++) begin
              slots_q[i] <= '0;
            end
            state_q <= COLLECT;
          end
        end
        default: begin
          state_q <= COLLECT;
        end
      endcase
    end
  end

endmodule
